// File: rtl/ram_sync_buf.sv
// Synchronous word buffer RAM with a req/ack access port and a hardware
// clear sequencer that zeroes every word after reset or on command.
// Reads are registered (1-cycle latency), so the array maps onto block RAM.
module ram_sync_buf #(
  parameter int WIDTH          = 12,
  parameter int AWIDTH         = 8,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  input  logic              req,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              ack
);

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  localparam state_e            RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
  localparam logic [AWIDTH-1:0] LAST      = AWIDTH'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   ctr_q, ctr_d;
  logic                ack_q, ack_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic                mem_we;
  logic [AWIDTH-1:0]   mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [WIDTH-1:0]    mem_rd;
  logic                in_range;
  logic                acc;

  // A full-size array has no unmapped addresses, so skip the compare there.
  generate
    if (DEPTH >= (1 << AWIDTH)) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
      assign in_range = ({1'b0, addr} < DEPTH_W);
    end
  endgenerate

  assign mem_rd = mem[addr];
  // A held req is not taken again in its own ack cycle: max one access per 2 clocks.
  assign acc    = (state_q == S_IDLE) && req && !clear && !ack_q;

  // Next-state, clear counter, access decode and memory write-port mux.
  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = ctr_q;
    mem_wdata = '0;

    if (clear) begin
      state_d = S_CLEAR;
      ctr_d   = '0;
    end else if (state_q == S_CLEAR) begin
      if (ctr_q == LAST) begin
        state_d = S_IDLE;
        ctr_d   = '0;
      end else begin
        ctr_d = ctr_q + 1'b1;
      end
    end

    // Zero one word per cycle while clearing; a restart just rewrites a zero.
    if (state_q == S_CLEAR) begin
      mem_we = 1'b1;
    end

    if (acc) begin
      ack_d = 1'b1;
      if (we) begin
        rdata_d   = wdata;
        mem_we    = in_range;
        mem_waddr = addr;
        mem_wdata = wdata;
      end else begin
        rdata_d = in_range ? mem_rd : '0;
      end
    end
  end

  // Control and output registers; reset drops ack/rdata without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      ctr_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array: no reset so it stays a plain block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busy  = (state_q == S_CLEAR);
  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule
